pipe_execute_stage: RTL and testbench

- Parametrised, pipelined successor to the single-cycle Y86-64 execute block.
- Contains the E pipeline register (decode→execute), the ALU, the condition-code register with exception-gated update, and cmov/jXX condition evaluation.
- Contains the M pipeline register (execute→memory).
- Sits between the decode/register-file stage and the memory stage of the PIPE processor. Exposes combinational e_valE/e_dstE for forwarding.

---
 rtl/pipe_execute_stage.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_execute_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_execute_stage.sv
// Execute stage of the pipelined Y86-64 core: E pipeline register, ALU, condition codes,
// cmov/jXX condition evaluation and the M pipeline register.
module pipe_execute_stage #(
  parameter int WIDTH  = 64,
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_e,
  input  logic              bubble_e,
  input  logic              bubble_m,
  input  logic [STAT_W-1:0] d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WIDTH-1:0]  d_valC,
  input  logic [WIDTH-1:0]  d_valA,
  input  logic [WIDTH-1:0]  d_valB,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic              m_exc,
  input  logic              w_exc,
  output logic [WIDTH-1:0]  e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [WIDTH-1:0]  M_valE,
  output logic [WIDTH-1:0]  M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
);

  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_INS = STAT_W'(4);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);

  logic [STAT_W-1:0] E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [WIDTH-1:0]  E_valC;
  logic [WIDTH-1:0]  E_valA;
  logic [WIDTH-1:0]  E_valB;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;

  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_r;
  logic              alu_of;
  logic              bad_op;
  logic              set_cc;
  logic              cond;
  logic [STAT_W-1:0] e_stat;

  // E register: stall wins over bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= R_NONE;
      E_dstM  <= R_NONE;
    end else if (stall_e) begin
      E_stat  <= E_stat;
    end else if (bubble_e) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= R_NONE;
      E_dstM  <= R_NONE;
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
    end
  end

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_CMOV, I_OPQ:           alu_a = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
      I_CALL, I_PUSH:          alu_a = -STACK_STEP;
      I_RET, I_POP:            alu_a = STACK_STEP;
      default:                 alu_a = '0;
    endcase

    alu_b = '0;
    case (E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_valB;
      default: alu_b = '0;
    endcase
  end

  always_comb begin
    bad_op = (E_icode == I_OPQ) && (E_ifun > 4'd3);
    alu_r  = alu_b + alu_a;
    alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
    if (E_icode == I_OPQ) begin
      case (E_ifun)
        4'd1: begin
          alu_r  = alu_b - alu_a;
          alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
        end
        4'd2: begin
          alu_r  = alu_b & alu_a;
          alu_of = 1'b0;
        end
        4'd3: begin
          alu_r  = alu_b ^ alu_a;
          alu_of = 1'b0;
        end
        default: ;
      endcase
    end
    e_valE = bad_op ? '0 : alu_r;
    set_cc = (E_icode == I_OPQ) && !bad_op && !m_exc && !w_exc && (E_stat == STAT_AOK);
    e_stat = (bad_op && (E_stat == STAT_AOK)) ? STAT_INS : E_stat;
  end

  // Conditions read the CC value held during this cycle, before any update at its end
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = (cc_sf ^ cc_of) | cc_zf;
      4'd2: cond = cc_sf ^ cc_of;
      4'd3: cond = cc_zf;
      4'd4: cond = !cc_zf;
      4'd5: cond = !(cc_sf ^ cc_of);
      4'd6: cond = !(cc_sf ^ cc_of) && !cc_zf;
      default: cond = 1'b0;
    endcase
    e_cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond : 1'b0;
    e_dstE = ((E_icode == I_CMOV) && !e_cnd) ? R_NONE : E_dstE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= (alu_r == '0);
      cc_sf <= alu_r[WIDTH-1];
      cc_of <= alu_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (bubble_m) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else begin
      M_stat  <= e_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Directed bench for pipe_execute_stage: a 64-bit instance for all features and a
// 32-bit instance sharing the same stimulus for the stack-step width dependence.
module tb_pipe_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_e, bubble_e, bubble_m;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;
  logic        m_exc, w_exc;

  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_cnd, M_cnd, cc_zf, cc_sf, cc_of;
  logic [2:0]  M_stat;

  logic [31:0] e_valE32, M_valE32, M_valA32;
  logic [3:0]  e_dstE32, M_icode32, M_dstE32, M_dstM32;
  logic        e_cnd32, M_cnd32, cc_zf32, cc_sf32, cc_of32;
  logic [2:0]  M_stat32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_execute_stage #(.WIDTH(64), .STAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .bubble_e(bubble_e), .bubble_m(bubble_m),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA),
    .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM), .m_exc(m_exc), .w_exc(w_exc),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .M_stat(M_stat), .M_icode(M_icode),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  pipe_execute_stage #(.WIDTH(32), .STAT_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .bubble_e(bubble_e), .bubble_m(bubble_m),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC[31:0]),
    .d_valA(d_valA[31:0]), .d_valB(d_valB[31:0]), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .m_exc(m_exc), .w_exc(w_exc),
    .e_valE(e_valE32), .e_dstE(e_dstE32), .e_cnd(e_cnd32), .M_stat(M_stat32),
    .M_icode(M_icode32), .M_cnd(M_cnd32), .M_valE(M_valE32), .M_valA(M_valA32),
    .M_dstE(M_dstE32), .M_dstM(M_dstM32), .cc_zf(cc_zf32), .cc_sf(cc_sf32), .cc_of(cc_of32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valC,
                       input logic [63:0] valA, input logic [63:0] valB, input logic [3:0] dstE);
    d_stat  = 3'd1;
    d_icode = icode;
    d_ifun  = ifun;
    d_valC  = valC;
    d_valA  = valA;
    d_valB  = valB;
    d_dstE  = dstE;
    d_dstM  = 4'hF;
  endtask

  task automatic drive_nop;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall_e = 1'b0; bubble_e = 1'b0; bubble_m = 1'b0;
    m_exc = 1'b0; w_exc = 1'b0;
    drive_nop();
    #12;
    checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_M_icode got %h exp 1", M_icode); end
    checks++; if (M_stat !== 3'd1) begin errors++; $display("FAIL reset_M_stat got %h exp 1", M_stat); end
    checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_M_dst got %h/%h exp F/F", M_dstE, M_dstM); end
    checks++; if (M_valE !== 64'h0 || M_cnd !== 1'b0) begin errors++; $display("FAIL reset_M_valE_cnd got %h/%b exp 0/0", M_valE, M_cnd); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL reset_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
    rst_n = 1'b1;
  endtask

  task automatic test_irmovq;
    drive(4'h3, 4'h0, 64'h10, 64'h0, 64'h0, 4'h2);
    tick();
    checks++; if (e_valE !== 64'h10 || e_dstE !== 4'h2) begin errors++; $display("FAIL irmov_e got %h/%h exp 10/2", e_valE, e_dstE); end
    checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL irmov_latency got M_icode %h exp 1", M_icode); end
    drive_nop();
    tick();
    checks++; if (M_icode !== 4'h3 || M_valE !== 64'h10 || M_dstE !== 4'h2) begin errors++; $display("FAIL irmov_M got %h/%h/%h exp 3/10/2", M_icode, M_valE, M_dstE); end
    checks++; if (cc_zf !== 1'b1 || M_cnd !== 1'b0) begin errors++; $display("FAIL irmov_cc got zf %b cnd %b exp 1/0", cc_zf, M_cnd); end
  endtask

  task automatic test_opq_flags;
    drive(4'h6, 4'h1, 64'h0, 64'd5, 64'd5, 4'h3);
    tick();
    checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL sub_e_valE got %h exp 0", e_valE); end
    drive(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3);
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL sub_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_e_valE got %h exp fffffffffffffffe", e_valE); end
    drive_nop();
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin errors++; $display("FAIL add_cc got %b exp 011", {cc_zf, cc_sf, cc_of}); end
  endtask

  task automatic test_alu_ops;
    logic [63:0] min_neg;
    min_neg = 64'h8000_0000_0000_0000;
    drive(4'h6, 4'h2, 64'h0, 64'hF0, 64'h3C, 4'h3);
    tick();
    checks++; if (e_valE !== 64'h30) begin errors++; $display("FAIL and_e_valE got %h exp 30", e_valE); end
    drive(4'h6, 4'h3, 64'h0, 64'hF0, 64'h3C, 4'h3);
    tick();
    checks++; if (e_valE !== 64'hCC) begin errors++; $display("FAIL xor_e_valE got %h exp cc", e_valE); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin errors++; $display("FAIL and_cc got %b exp 000", {cc_zf, cc_sf, cc_of}); end
    drive(4'h6, 4'h5, 64'h0, 64'd1, 64'd1, 4'h3);
    tick();
    checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL badop_e_valE got %h exp 0", e_valE); end
    drive(4'h6, 4'h1, 64'h0, 64'd1, min_neg, 4'h3);
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin errors++; $display("FAIL badop_cc_held got %b exp 000", {cc_zf, cc_sf, cc_of}); end
    checks++; if (M_stat !== 3'd4 || M_icode !== 4'h6) begin errors++; $display("FAIL badop_M_stat got %h/%h exp 4/6", M_stat, M_icode); end
    checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL subov_e_valE got %h exp 7fffffffffffffff", e_valE); end
    drive_nop();
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin errors++; $display("FAIL subov_cc got %b exp 001", {cc_zf, cc_sf, cc_of}); end
  endtask

  task automatic test_cond;
    logic [7:0] exp_j;
    exp_j = 8'b0001_0111;
    drive(4'h6, 4'h1, 64'h0, 64'd1, 64'd0, 4'h3);
    tick();
    drive(4'h2, 4'h2, 64'h0, 64'h55, 64'h0, 4'h3);
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("FAIL cond_setup_cc got %b exp 010", {cc_zf, cc_sf, cc_of}); end
    checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h3 || e_valE !== 64'h55) begin errors++; $display("FAIL cmovl_e got %b/%h/%h exp 1/3/55", e_cnd, e_dstE, e_valE); end
    drive(4'h2, 4'h3, 64'h0, 64'h66, 64'h0, 4'h4);
    tick();
    checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin errors++; $display("FAIL cmove_e got %b/%h exp 0/F", e_cnd, e_dstE); end
    checks++; if (M_cnd !== 1'b1 || M_dstE !== 4'h3) begin errors++; $display("FAIL cmovl_M got %b/%h exp 1/3", M_cnd, M_dstE); end
    drive_nop();
    tick();
    checks++; if (M_cnd !== 1'b0 || M_dstE !== 4'hF || M_icode !== 4'h2) begin errors++; $display("FAIL cmove_M got %b/%h/%h exp 0/F/2", M_cnd, M_dstE, M_icode); end
    for (int i = 0; i < 8; i++) begin
      drive(4'h7, 4'(i), 64'h0, 64'h0, 64'h0, 4'hF);
      tick();
      checks++; if (e_cnd !== exp_j[i]) begin errors++; $display("FAIL jxx_ifun%0d got %b exp %b", i, e_cnd, exp_j[i]); end
    end
  endtask

  task automatic test_exc_gate;
    drive(4'h6, 4'h0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3);
    m_exc = 1'b1;
    tick();
    checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL mexc_e_valE got %h exp 0", e_valE); end
    drive_nop();
    tick();
    m_exc = 1'b0;
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("FAIL mexc_cc_held got %b exp 010", {cc_zf, cc_sf, cc_of}); end
    drive(4'h6, 4'h0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3);
    tick();
    drive_nop();
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL noexc_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
    drive(4'h6, 4'h1, 64'h0, 64'd1, 64'd0, 4'h3);
    w_exc = 1'b1;
    tick();
    drive_nop();
    tick();
    w_exc = 1'b0;
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL wexc_cc_held got %b exp 100", {cc_zf, cc_sf, cc_of}); end
    drive(4'h6, 4'h1, 64'h0, 64'd1, 64'd0, 4'h3);
    d_stat = 3'd3;
    tick();
    drive_nop();
    tick();
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100 || M_stat !== 3'd3) begin errors++; $display("FAIL adr_stat got cc %b stat %h exp 100/3", {cc_zf, cc_sf, cc_of}, M_stat); end
  endtask

  task automatic test_stack;
    drive(4'hA, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    tick();
    checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL push_e_valE got %h exp f8", e_valE); end
    checks++; if (e_valE32 !== 32'hFC) begin errors++; $display("FAIL push32_e_valE got %h exp fc", e_valE32); end
    drive(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    tick();
    checks++; if (e_valE !== 64'h108) begin errors++; $display("FAIL pop_e_valE got %h exp 108", e_valE); end
    checks++; if (e_valE32 !== 32'h104) begin errors++; $display("FAIL pop32_e_valE got %h exp 104", e_valE32); end
    drive(4'h8, 4'h0, 64'h0, 64'h0, 64'h200, 4'h4);
    tick();
    checks++; if (e_valE !== 64'h1F8) begin errors++; $display("FAIL call_e_valE got %h exp 1f8", e_valE); end
    drive(4'h9, 4'h0, 64'h0, 64'h0, 64'h200, 4'h4);
    tick();
    checks++; if (e_valE !== 64'h208) begin errors++; $display("FAIL ret_e_valE got %h exp 208", e_valE); end
    drive(4'h5, 4'h0, 64'h18, 64'h0, 64'h200, 4'hF);
    tick();
    checks++; if (e_valE !== 64'h218) begin errors++; $display("FAIL mrmov_e_valE got %h exp 218", e_valE); end
    drive(4'h0, 4'h0, 64'h18, 64'h33, 64'h200, 4'hF);
    tick();
    checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL halt_e_valE got %h exp 0", e_valE); end
  endtask

  task automatic test_stall_bubble;
    drive(4'h3, 4'h0, 64'h77, 64'h0, 64'h0, 4'h5);
    tick();
    stall_e = 1'b1; bubble_e = 1'b1;
    drive(4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h6);
    tick();
    checks++; if (e_valE !== 64'h77 || M_valE !== 64'h77) begin errors++; $display("FAIL stall1 got e %h M %h exp 77/77", e_valE, M_valE); end
    drive(4'h3, 4'h0, 64'hAA, 64'h0, 64'h0, 4'h7);
    tick();
    checks++; if (e_valE !== 64'h77 || M_dstE !== 4'h5 || M_icode !== 4'h3) begin errors++; $display("FAIL stall2 got e %h M_dstE %h M_icode %h exp 77/5/3", e_valE, M_dstE, M_icode); end
    stall_e = 1'b0;
    tick();
    checks++; if (e_valE !== 64'h0 || e_dstE !== 4'hF) begin errors++; $display("FAIL bubble_e got %h/%h exp 0/F", e_valE, e_dstE); end
    bubble_e = 1'b0;
    drive(4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h6);
    tick();
    checks++; if (e_valE !== 64'h99 || M_icode !== 4'h1) begin errors++; $display("FAIL after_bubble got e %h M_icode %h exp 99/1", e_valE, M_icode); end
    bubble_m = 1'b1;
    drive_nop();
    tick();
    bubble_m = 1'b0;
    checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'h0) begin errors++; $display("FAIL bubble_m got %h/%h/%h exp 1/F/0", M_icode, M_dstE, M_valE); end
  endtask

  task automatic test_reset_mid;
    drive(4'h6, 4'h1, 64'h0, 64'd1, 64'd0, 4'h3);
    tick();
    drive(4'h3, 4'h0, 64'h44, 64'h0, 64'h0, 4'h2);
    tick();
    drive_nop();
    tick();
    checks++; if (M_icode !== 4'h3 || cc_zf !== 1'b0 || cc_sf !== 1'b1) begin errors++; $display("FAIL premid got M_icode %h zf %b sf %b exp 3/0/1", M_icode, cc_zf, cc_sf); end
    drive(4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'h2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF) begin errors++; $display("FAIL midrst_M got %h/%h exp 1/F", M_icode, M_dstE); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100 || e_valE !== 64'h0) begin errors++; $display("FAIL midrst_cc got %b e %h exp 100/0", {cc_zf, cc_sf, cc_of}, e_valE); end
    #1;
    rst_n = 1'b1;
    drive_nop();
    tick();
    tick();
    checks++; if (M_icode !== 4'h1 || M_valE !== 64'h0) begin errors++; $display("FAIL postrst got %h/%h exp 1/0", M_icode, M_valE); end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_opq_flags();
    test_alu_ops();
    test_cond();
    test_exc_gate();
    test_stack();
    test_stall_bubble();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
